// File: rtl/alu_srcb_stage.sv
//-----------------------------------------------------------------------------
// alu_srcb_stage
//
// Selects the ALU operand-B source from a 3-bit selector code and queues the
// resulting operand in a small FIFO towards the execute stage. Every pushed
// operand appears at data_out exactly one cycle later (no bypass path from
// the inputs to data_out). The queue is a plain register array with
// wrap-around read/write pointers; the control outputs in_ready, out_valid
// and count are all registered.
//
// Parameters
//   WIDTH  datapath width (18 or more)
//   INC    constant produced by selector code 001, truncated to WIDTH
//   DEPTH  number of buffer entries (power of two, 2 or more)
//
// Ports
//   clk        in   rising-edge clock, sole clock domain
//   reset      in   synchronous active-high reset
//   seletor    in   operand-B source select, sampled on push
//   B_out      in   register B value
//   imm16      in   instruction immediate field
//   in_valid   in   upstream offers an operand request
//   in_ready   out  request accepted this cycle (buffer not full)
//   flush      in   discard all buffered operands
//   data_out   out  oldest buffered operand
//   out_valid  out  data_out holds a valid operand
//   out_ready  in   consumer takes data_out this cycle
//   count      out  current buffer occupancy
//   sel_err    out  sticky flag: an illegal selector code was pushed
//-----------------------------------------------------------------------------
module alu_srcb_stage #(
   parameter int WIDTH = 32,
   parameter int INC   = 4,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               seletor,
   input  logic [WIDTH-1:0]         B_out,
   input  logic [15:0]              imm16,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [WIDTH-1:0]         data_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sel_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);

   //--------------------------------------------------------------------------
   // Operand decode helpers
   //--------------------------------------------------------------------------

   // Codes 101..111 are not assigned to any operand source.
   function automatic logic is_illegal_sel(input logic [2:0] sel);
      logic illegal;
      case (sel)
         3'b101, 3'b110, 3'b111: illegal = 1'b1;
         default:                illegal = 1'b0;
      endcase
      return illegal;
   endfunction

   // Builds the operand for one selector code. The shifted immediate is the
   // branch-offset form: sign-extend first, then shift, so bits pushed past
   // WIDTH are simply lost.
   function automatic logic [WIDTH-1:0] decode_operand(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] reg_b,
      input logic [15:0]      imm
   );
      logic [WIDTH-1:0] imm_sext;
      logic [WIDTH-1:0] imm_zext;
      logic [WIDTH-1:0] operand;
      imm_sext = {{(WIDTH-16){imm[15]}}, imm};
      imm_zext = {{(WIDTH-16){1'b0}}, imm};
      case (sel)
         3'b000:  operand = reg_b;
         3'b001:  operand = INC_W;
         3'b010:  operand = imm_sext;
         3'b011:  operand = imm_sext << 2;
         3'b100:  operand = imm_zext;
         default: operand = {WIDTH{1'b0}};
      endcase
      return operand;
   endfunction

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_err_q, sel_err_d;

   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] operand_s;
   logic             illegal_s;

   //--------------------------------------------------------------------------
   // Handshake qualification and operand decode
   //--------------------------------------------------------------------------

   // Flush kills both handshakes; in_ready/out_valid are the registered flags,
   // so neither side sees a combinational path from the other.
   always_comb begin
      push_s    = in_valid & in_ready_q & ~flush;
      pop_s     = out_valid_q & out_ready & ~flush;
      operand_s = decode_operand(seletor, B_out, imm16);
      illegal_s = is_illegal_sel(seletor);
   end

   //--------------------------------------------------------------------------
   // Next-state logic for pointers, occupancy, flags
   //--------------------------------------------------------------------------

   // Pointers wrap naturally because DEPTH is a power of two. Flush wins over
   // push and pop; the error flag is not touched by flush.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      sel_err_d = sel_err_q | (push_s & illegal_s);

      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            2'b11:   count_d = count_q;
            2'b00:   count_d = count_q;
            default: count_d = count_q;
         endcase
      end

      // Flags are precomputed from the next occupancy so they leave a flop.
      in_ready_d  = (count_d < DEPTH_C);
      out_valid_d = (count_d != {CW{1'b0}});
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------

   // Control state register; reset overrides flush, push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // Operand storage; contents survive reset, stale entries are unreachable
   // because the pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         mem_q[wr_ptr_q] <= operand_s;
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign data_out  = mem_q[rd_ptr_q];
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign count     = count_q;
   assign sel_err   = sel_err_q;

endmodule

// File: doc/alu_srcb_stage.md
ALU_SRCB_STAGE -- requirements
Module: alu_srcb_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; legal range is 18 or more.
REQ-002 The block SHALL have parameter INC, default 4, the increment constant for selector code 001, truncated to WIDTH.
REQ-003 The block SHALL have parameter DEPTH, default 2, output buffer entries; legal values are powers of two, 2 or more.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock, sole clock domain.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 seletor  input  3  operand-B source select, sampled on push.
REQ-008 B_out  input  WIDTH  register B value.
REQ-009 imm16  input  16  instruction immediate field.
REQ-010 in_valid  input  1  upstream offers an operand request.
REQ-011 in_ready  output  1  block accepts a request this cycle.
REQ-012 flush  input  1  discard all buffered operands.
REQ-013 data_out  output  WIDTH  head-of-buffer operand.
REQ-014 out_valid  output  1  data_out is valid.
REQ-015 out_ready  input  1  consumer takes data_out this cycle.
REQ-016 count  output  clog2(DEPTH)+1  current buffer occupancy.
REQ-017 sel_err  output  1  sticky flag: an illegal selector code was pushed.

Function
REQ-018 The block SHALL define push as in_valid && in_ready && !flush, and pop as out_valid && out_ready && !flush.
REQ-019 The block SHALL compute the pushed operand from the selector code as follows.
- 000: B_out.
- 001: INC.
- 010: sign-extended imm16.
- 011: sign-extended imm16 shifted left 2, with upper bits discarded at WIDTH.
- 100: zero-extended imm16.
- 101, 110, 111: all zeros.
REQ-020 The block SHALL set sel_err to 1 on the clock edge after a push whose code is 101-111; sel_err SHALL then hold 1 until reset, and flush SHALL NOT clear it.
REQ-021 The block SHALL store pushed operands in a FIFO of DEPTH entries with wrap-around read and write pointers.
REQ-022 Latency from push to out_valid SHALL be exactly 1 cycle; there is no combinational bypass from inputs to data_out.
REQ-023 The block SHALL drive in_ready = (count < DEPTH), with no dependence on out_ready in the same cycle.
REQ-024 The block SHALL drive out_valid = (count != 0), and data_out SHALL always equal the oldest entry.
REQ-025 When a push and a pop occur in the same cycle, count SHALL be unchanged and order SHALL be preserved; this is legal at any occupancy from 1 to DEPTH-1.
REQ-026 When full, in_ready SHALL be 0 and an in_valid request SHALL be held upstream, not dropped; a pop while full SHALL raise in_ready on the next cycle.
REQ-027 When empty, out_valid SHALL be 0 and out_ready SHALL be ignored; count SHALL never underflow.
REQ-028 On flush, the next edge SHALL set count to 0 and both pointers to 0; a request presented with flush is dropped, and flush has priority over push and pop.
REQ-029 data_out while out_valid=0 SHALL be don't-care, and the bench SHALL NOT check it.

Reset
REQ-030 On reset, the next edge SHALL set count=0, out_valid=0, in_ready=1, sel_err=0, and both pointers to 0.
REQ-031 Reset SHALL have priority over flush, push and pop; buffer contents are not cleared.
REQ-032 Reset asserted mid-stream SHALL discard all buffered operands, and no stale operand SHALL appear after reset deasserts.

Verification
REQ-033 Decode: WIDTH=32; push codes 000-100 with B_out=0x12345678 and imm16=0x8001 -> outputs 0x12345678, 0x00000004, 0xFFFF8001, 0xFFFE0004, 0x00008001, in order, each 1 cycle after push.
REQ-034 Backpressure: DEPTH=2, out_ready=0; push 3 requests -> count=2, in_ready=0, and the third request is held; then out_ready=1 for 1 cycle -> first operand popped and the third accepted next cycle.
REQ-035 Simultaneous: count=1; push and pop in the same cycle -> count stays 1, and data_out becomes the second operand.
REQ-036 Illegal code: push 110 -> data_out=0 and sel_err=1 on the next cycle; apply flush -> count=0 and sel_err still 1; apply reset -> sel_err=0.
REQ-037 Flush/reset mid-operation: count=2 with flush and in_valid both asserted -> count=0 and the request dropped; repeat with reset -> identical state, in_ready=1.
REQ-038 Wrap-around: DEPTH=4; stream 20 operands at a random out_ready duty cycle -> output order and values match the pushed sequence, with no loss or duplication.
